// File: rtl/write_to_ddr3.sv
// Frame-buffer writer: drains a show-ahead pixel FIFO into one of two DDR3
// frame buffers with 4-beat Avalon-MM write bursts, alternating buffers per
// frame, and tracks which buffers hold a complete frame for the reader.
module write_to_ddr3 #(
    parameter int          IMAGE_WIDTH    = 1280,
    parameter int          IMAGE_HEIGHT   = 1024,
    parameter logic [25:0] BUFFER0_OFFSET = 26'd0,
    parameter logic [25:0] BUFFER1_OFFSET = 26'h0200000
) (
    input  logic        ddr3_clk,
    input  logic        ddr3_reset_n,
    input  logic [31:0] src_fifo_data,
    input  logic [10:0] src_fifo_usedw,
    output logic        src_fifo_rd,
    input  logic        buffer0_release,
    input  logic        buffer1_release,
    output logic        ddr3_rd_buffer0_empty,
    output logic        ddr3_rd_buffer1_empty,
    output logic        frame_written,
    input  logic        ddr3_avl_ready,
    output logic        ddr3_avl_burstbegin,
    output logic [2:0]  ddr3_avl_size,
    output logic        ddr3_avl_write_req,
    output logic [25:0] ddr3_avl_addr,
    output logic [31:0] ddr3_avl_wdata
);

    // Index of the last 4-word burst in a frame.
    localparam logic [31:0] MAX_BURST = 32'(((IMAGE_WIDTH * IMAGE_HEIGHT) >> 2) - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t      state_q;
    logic        write_req_q;
    logic        frame_written_q;
    logic        empty0_q;
    logic        empty1_q;
    logic        write_sel_q;
    logic [25:0] addr_q;
    logic [31:0] burst_count_q;
    logic [1:0]  beat_count_q;

    logic        target_empty;

    assign target_empty = write_sel_q ? empty1_q : empty0_q;

    // Burst sequencer, buffer ownership and empty-flag bookkeeping.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_q         <= IDLE;
            write_req_q     <= 1'b0;
            frame_written_q <= 1'b0;
            empty0_q        <= 1'b1;
            empty1_q        <= 1'b1;
            write_sel_q     <= 1'b0;
            addr_q          <= BUFFER0_OFFSET;
            burst_count_q   <= '0;
            beat_count_q    <= '0;
        end else begin
            frame_written_q <= 1'b0;
            // Releases apply first so a same-cycle DONE on that buffer wins.
            if (buffer0_release) empty0_q <= 1'b1;
            if (buffer1_release) empty1_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (target_empty && (src_fifo_usedw >= 11'd4)) begin
                        state_q     <= BURST;
                        write_req_q <= 1'b1;
                    end
                end
                BURST: begin
                    // ready low holds every output and the beat counter.
                    if (ddr3_avl_ready) begin
                        beat_count_q <= beat_count_q + 2'd1;
                        if (beat_count_q == 2'd3) begin
                            write_req_q <= 1'b0;
                            if (burst_count_q == MAX_BURST) begin
                                state_q         <= DONE;
                                frame_written_q <= 1'b1;
                            end else begin
                                burst_count_q <= burst_count_q + 32'd1;
                                addr_q        <= addr_q + 26'd4;
                                state_q       <= IDLE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (write_sel_q) empty1_q <= 1'b0;
                    else             empty0_q <= 1'b0;
                    write_sel_q   <= ~write_sel_q;
                    burst_count_q <= '0;
                    addr_q        <= write_sel_q ? BUFFER0_OFFSET : BUFFER1_OFFSET;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A beat is popped from the show-ahead FIFO in the cycle it is accepted.
    assign src_fifo_rd           = write_req_q & ddr3_avl_ready;
    assign ddr3_avl_burstbegin   = write_req_q & (beat_count_q == 2'd0);
    assign ddr3_avl_write_req    = write_req_q;
    assign ddr3_avl_size         = 3'b100;
    assign ddr3_avl_addr         = addr_q;
    assign ddr3_avl_wdata        = src_fifo_data;
    assign ddr3_rd_buffer0_empty = empty0_q;
    assign ddr3_rd_buffer1_empty = empty1_q;
    assign frame_written         = frame_written_q;

endmodule

// File: tb/tb_write_to_ddr3.sv
// Bench for write_to_ddr3 with a 8x2 image (4 bursts per frame). A FIFO model
// feeds pixels; every pushed pixel also queues its expected bus beat, which a
// monitor pops and compares on each accepted beat.
module tb_write_to_ddr3;

    localparam logic [25:0] OFF0 = 26'd0;
    localparam logic [25:0] OFF1 = 26'h0200000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_fifo_data = '0;
    logic [10:0] src_fifo_usedw = '0;
    logic        src_fifo_rd;
    logic        rel0 = 1'b0, rel1 = 1'b0;
    logic        empty0, empty1, frame_written;
    logic        ready = 1'b1;
    logic        bb, write_req;
    logic [2:0]  size;
    logic [25:0] addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    write_to_ddr3 #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2),
                    .BUFFER0_OFFSET(OFF0), .BUFFER1_OFFSET(OFF1)) dut (
        .ddr3_clk(clk), .ddr3_reset_n(rst_n),
        .src_fifo_data(src_fifo_data), .src_fifo_usedw(src_fifo_usedw),
        .src_fifo_rd(src_fifo_rd),
        .buffer0_release(rel0), .buffer1_release(rel1),
        .ddr3_rd_buffer0_empty(empty0), .ddr3_rd_buffer1_empty(empty1),
        .frame_written(frame_written),
        .ddr3_avl_ready(ready), .ddr3_avl_burstbegin(bb), .ddr3_avl_size(size),
        .ddr3_avl_write_req(write_req), .ddr3_avl_addr(addr), .ddr3_avl_wdata(wdata)
    );

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] data;
        logic        bb;
    } beat_t;

    int          vectors = 0, miscompares = 0;
    logic [31:0] fifo_q[$];
    beat_t       exp_q[$];
    int          usedw_force = -1;
    bit          ready_toggle = 0;
    int          pops = 0, beats = 0, fw_count = 0, wreq_seen = 0;
    logic [31:0] word_seed = 32'hA5000000;
    logic        pop_s;
    logic [31:0] junk;
    beat_t       e;

    // FIFO model: pop on the edge the DUT reads, then refresh head/usedw.
    always @(posedge clk) begin
        pop_s = src_fifo_rd;
        #1;
        if (pop_s && fifo_q.size() > 0) junk = fifo_q.pop_front();
        src_fifo_usedw = (usedw_force >= 0) ? 11'(usedw_force) : 11'(fifo_q.size());
        src_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        ready = ready_toggle ? ~ready : 1'b1;
    end

    // Scoreboard monitor: compare every accepted beat against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (src_fifo_rd)   pops++;
            if (frame_written) fw_count++;
            if (write_req)     wreq_seen++;
            if (write_req && ready) begin
                beats++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected got addr=%h data=%h", addr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (addr !== e.addr || wdata !== e.data || bb !== e.bb || src_fifo_rd !== 1'b1) begin
                        miscompares++;
                        $display("FAIL beat got addr=%h data=%h bb=%b rd=%b exp addr=%h data=%h bb=%b rd=1",
                                 addr, wdata, bb, src_fifo_rd, e.addr, e.data, e.bb);
                    end
                end
            end
        end
    end

    task automatic push_words(input logic [25:0] base, input int n, input int first_burst);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(word_seed);
            b.addr = base + 26'(4 * (first_burst + i / 4));
            b.data = word_seed;
            b.bb   = (i % 4 == 0);
            exp_q.push_back(b);
            word_seed = word_seed + 32'h00010003;
        end
    endtask

    // Returns at the edge that closes the DONE cycle (or after a timeout).
    task automatic wait_frame(output bit ok);
        int start = fw_count;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (fw_count > start) begin ok = 1; break; end
        end
        #2;
    endtask

    task automatic pulse_release(input bit which);
        @(posedge clk); #2;
        if (which) rel1 = 1'b1; else rel0 = 1'b1;
        @(posedge clk); #2;
        rel0 = 1'b0; rel1 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({write_req, bb, src_fifo_rd, frame_written, empty0, empty1} !== 6'b000011) begin
            miscompares++;
            $display("FAIL reset_ctrl got wr,bb,rd,fw,e0,e1=%b exp 000011",
                     {write_req, bb, src_fifo_rd, frame_written, empty0, empty1});
        end
        vectors++;
        if (addr !== OFF0) begin miscompares++; $display("FAIL reset_addr got %h exp %h", addr, OFF0); end
        vectors++;
        if (size !== 3'b100) begin miscompares++; $display("FAIL size got %b exp 100", size); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_frame();
        bit ok;
        push_words(OFF0, 16, 0);
        wait_frame(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL frame0_timeout got none exp frame_written"); end
        vectors++;
        if ({empty0, empty1} !== 2'b01) begin miscompares++; $display("FAIL frame0_flags got %b exp 01", {empty0, empty1}); end
        vectors++;
        if (addr !== OFF1) begin miscompares++; $display("FAIL frame0_next_addr got %h exp %h", addr, OFF1); end
        repeat (3) @(posedge clk); #2;
        vectors++;
        if (fw_count !== 1 || beats !== 16 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL frame0_counts got fw=%0d beats=%0d left=%0d exp 1 16 0", fw_count, beats, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int p0 = pops;
        ready_toggle = 1;
        push_words(OFF1, 16, 0);
        wait_frame(ok);
        ready_toggle = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stall_timeout got none exp frame_written"); end
        vectors++;
        if (pops - p0 !== 16 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_pops got %0d left=%0d exp 16 0", pops - p0, exp_q.size());
        end
        vectors++;
        if ({empty0, empty1} !== 2'b00 || addr !== OFF0) begin
            miscompares++;
            $display("FAIL stall_flags got %b addr=%h exp 00 addr=%h", {empty0, empty1}, addr, OFF0);
        end
    endtask

    task automatic test_park();
        bit ok;
        int w0 = wreq_seen;
        push_words(OFF0, 16, 0);
        repeat (12) @(posedge clk); #2;
        vectors++;
        if (wreq_seen !== w0 || write_req !== 1'b0 || fifo_q.size() !== 16) begin
            miscompares++;
            $display("FAIL park got wreq_cycles=%0d fifo=%0d exp 0 16", wreq_seen - w0, fifo_q.size());
        end
        pulse_release(1'b0);
        vectors++;
        if (empty0 !== 1'b1) begin miscompares++; $display("FAIL release0 got %b exp 1", empty0); end
        wait_frame(ok);
        vectors++;
        if (!ok || exp_q.size() !== 0 || empty0 !== 1'b0) begin
            miscompares++;
            $display("FAIL park_resume got ok=%0d left=%0d e0=%b exp 1 0 0", ok, exp_q.size(), empty0);
        end
    endtask

    task automatic test_release_collision();
        bit ok;
        bit seen = 0;
        pulse_release(1'b1);
        push_words(OFF1, 16, 0);
        wait_frame(ok);
        vectors++;
        if (!ok || empty1 !== 1'b0) begin miscompares++; $display("FAIL coll_setup got ok=%0d e1=%b exp 1 0", ok, empty1); end
        pulse_release(1'b0);
        push_words(OFF0, 16, 0);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            if (frame_written) begin seen = 1; break; end
        end
        rel1 = 1'b1;
        @(posedge clk); #2;
        rel1 = 1'b0;
        vectors++;
        if (!seen || {empty0, empty1} !== 2'b01) begin
            miscompares++;
            $display("FAIL coll_flags got seen=%0d e0e1=%b exp 1 01", seen, {empty0, empty1});
        end
    endtask

    task automatic test_usedw();
        int w0 = wreq_seen;
        usedw_force = 3;
        push_words(OFF1, 4, 0);
        repeat (8) @(posedge clk); #2;
        vectors++;
        if (wreq_seen !== w0 || write_req !== 1'b0) begin
            miscompares++;
            $display("FAIL usedw3 got wreq_cycles=%0d exp 0", wreq_seen - w0);
        end
        usedw_force = 4;
        @(posedge clk); #2;
        vectors++;
        if (write_req !== 1'b0) begin miscompares++; $display("FAIL usedw4_early got %b exp 0", write_req); end
        @(posedge clk); #2;
        vectors++;
        if (write_req !== 1'b1 || bb !== 1'b1) begin
            miscompares++;
            $display("FAIL usedw4_burst got wr=%b bb=%b exp 1 1", write_req, bb);
        end
        usedw_force = -1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL usedw_drain got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int b0 = beats;
        push_words(OFF1, 4, 1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (beats >= b0 + 1) break;
        end
        vectors++;
        if (beats !== b0 + 1 || write_req !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_setup got beats=%0d wr=%b exp %0d 1", beats - b0, write_req, 1);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({write_req, bb, src_fifo_rd, frame_written, empty0, empty1} !== 6'b000011 || addr !== OFF0) begin
            miscompares++;
            $display("FAIL midburst_reset got wr,bb,rd,fw,e0,e1=%b addr=%h exp 000011 addr=%h",
                     {write_req, bb, src_fifo_rd, frame_written, empty0, empty1}, addr, OFF0);
        end
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk); rst_n = 1'b1;
        push_words(OFF0, 16, 0);
        wait_frame(ok);
        vectors++;
        if (!ok || exp_q.size() !== 0 || {empty0, empty1} !== 2'b01) begin
            miscompares++;
            $display("FAIL after_reset got ok=%0d left=%0d e0e1=%b exp 1 0 01", ok, exp_q.size(), {empty0, empty1});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_park();
        test_release_collision();
        test_usedw();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
